game_fx_sequencer: RTL and testbench

Frame-synchronous effects sequencer driving rotation, HSL colour offsets, wall-advance strobes and colour inversion for the renderer. Successor to the fixed-rate game controller: all widths and rates parametrised, adds level progression, rotation-direction reversal, a luminance pulse and a game-over fade. Sits between the game FSM (State) and the colour mapper / wall generator, clocked on Clk, timed by VGA_VS.

---
 rtl/game_fx_sequencer.sv | 176 +++++++++++++++++
 tb/tb_game_fx_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_fx_sequencer.sv
// Frame-synchronous effects sequencer: rotation, HSL offsets, wall strobes and
// colour inversion, all advanced once per VGA frame on the rising edge of VGA_VS.
//
// mode   | meaning
// -------+-------------------------------------------------------------
// M_IDLE | attract loop: fixed-rate spin, hue drift, full sat/lum
// M_PLAY | gameplay: levelled spin with reversals, lum pulse, walls, invert
// M_OVER | game over: motion frozen, saturation and luminance fade to 0
module game_fx_sequencer #(
    parameter int ROT_W            = 10,
    parameter int HUE_W            = 6,
    parameter int SL_W             = 5,
    parameter int LVL_W            = 3,
    parameter int ROT_BASE         = 2,
    parameter int ROT_STEP         = 1,
    parameter int REV_FRAMES       = 120,
    parameter int FRAMES_PER_LEVEL = 600,
    parameter int WALL_DIV         = 4,
    parameter int HUE_DIV          = 2,
    parameter int LUM_MIN          = 16,
    parameter int INVERT_LEVEL     = 3,
    parameter int INVERT_PERIOD    = 60
) (
    input  logic             Clk,
    input  logic             Reset_h,
    input  logic             VGA_VS,
    input  logic [2:0]       State,
    output logic [ROT_W-1:0] rotation_offset,
    output logic [HUE_W-1:0] Hue_offset,
    output logic [SL_W-1:0]  Saturation_offset,
    output logic [SL_W-1:0]  Luminance_offset,
    output logic             move_walls,
    output logic             invert_colors,
    output logic [LVL_W-1:0] level
);

    localparam int REV_CW = $clog2(REV_FRAMES + 1);
    localparam int LVL_CW = $clog2(FRAMES_PER_LEVEL + 1);
    localparam int WAL_CW = $clog2(WALL_DIV + 1);
    localparam int HUE_CW = $clog2(HUE_DIV + 1);
    localparam int INV_CW = $clog2(INVERT_PERIOD + 1);
    localparam logic [SL_W-1:0] LUM_LO = SL_W'(LUM_MIN);

    typedef enum logic [1:0] {M_IDLE = 2'd0, M_PLAY = 2'd1, M_OVER = 2'd2} mode_t;

    mode_t             mode, mode_nxt;
    logic              vs_q, tick, enter_play;
    logic              dir_neg, lum_up;
    logic [REV_CW-1:0] rev_cnt;
    logic [LVL_CW-1:0] lvl_cnt;
    logic [WAL_CW-1:0] wall_cnt;
    logic [HUE_CW-1:0] hue_cnt;
    logic [INV_CW-1:0] inv_cnt;
    logic [ROT_W-1:0]  step;

    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) mode <= M_IDLE;
        else         mode <= mode_nxt;
    end

    always_comb begin
        mode_nxt = M_IDLE;
        case (State)
            3'd1:    mode_nxt = M_PLAY;
            3'd2:    mode_nxt = M_OVER;
            default: mode_nxt = M_IDLE;
        endcase
    end

    assign tick       = VGA_VS & ~vs_q;
    assign enter_play = (mode_nxt == M_PLAY) && (mode != M_PLAY);
    assign step       = ROT_W'(ROT_BASE) + ROT_W'(level) * ROT_W'(ROT_STEP);

    // Behaviour keys off the decoded State so a mode change and its effects land on the same edge.
    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            vs_q              <= 1'b1;
            rotation_offset   <= '0;
            Hue_offset        <= '0;
            Saturation_offset <= '1;
            Luminance_offset  <= '1;
            move_walls        <= 1'b0;
            invert_colors     <= 1'b0;
            level             <= '0;
            dir_neg           <= 1'b0;
            lum_up            <= 1'b0;
            rev_cnt           <= '0;
            lvl_cnt           <= '0;
            wall_cnt          <= '0;
            hue_cnt           <= '0;
            inv_cnt           <= '0;
        end else begin
            vs_q       <= VGA_VS;
            move_walls <= 1'b0;
            if (enter_play) begin
                level             <= '0;
                rev_cnt           <= '0;
                lvl_cnt           <= '0;
                wall_cnt          <= '0;
                hue_cnt           <= '0;
                inv_cnt           <= '0;
                invert_colors     <= 1'b0;
                dir_neg           <= 1'b0;
                lum_up            <= 1'b0;
                Saturation_offset <= '1;
                Luminance_offset  <= '1;
            end else if (tick) begin
                if (mode_nxt != M_OVER) begin
                    if (hue_cnt == HUE_CW'(HUE_DIV - 1)) begin
                        hue_cnt    <= '0;
                        Hue_offset <= Hue_offset + 1'b1;
                    end else begin
                        hue_cnt <= hue_cnt + 1'b1;
                    end
                end
                case (mode_nxt)
                    M_PLAY: begin
                        rotation_offset <= dir_neg ? rotation_offset - step : rotation_offset + step;
                        if (rev_cnt == REV_CW'(REV_FRAMES - 1)) begin
                            rev_cnt <= '0;
                            dir_neg <= ~dir_neg;
                        end else begin
                            rev_cnt <= rev_cnt + 1'b1;
                        end
                        if (lum_up) begin
                            if (Luminance_offset == '1) begin
                                lum_up           <= 1'b0;
                                Luminance_offset <= Luminance_offset - 1'b1;
                            end else begin
                                Luminance_offset <= Luminance_offset + 1'b1;
                            end
                        end else begin
                            if (Luminance_offset <= LUM_LO) begin
                                lum_up           <= 1'b1;
                                Luminance_offset <= Luminance_offset + 1'b1;
                            end else begin
                                Luminance_offset <= Luminance_offset - 1'b1;
                            end
                        end
                        if (wall_cnt == WAL_CW'(WALL_DIV - 1)) begin
                            wall_cnt   <= '0;
                            move_walls <= 1'b1;
                        end else begin
                            wall_cnt <= wall_cnt + 1'b1;
                        end
                        if (lvl_cnt == LVL_CW'(FRAMES_PER_LEVEL - 1)) begin
                            lvl_cnt <= '0;
                            if (level != '1) level <= level + 1'b1;
                        end else begin
                            lvl_cnt <= lvl_cnt + 1'b1;
                        end
                        if (level >= LVL_W'(INVERT_LEVEL)) begin
                            if (inv_cnt == INV_CW'(INVERT_PERIOD - 1)) begin
                                inv_cnt       <= '0;
                                invert_colors <= ~invert_colors;
                            end else begin
                                inv_cnt <= inv_cnt + 1'b1;
                            end
                        end
                    end
                    M_OVER: begin
                        if (Saturation_offset != '0) Saturation_offset <= Saturation_offset - 1'b1;
                        if (Luminance_offset != '0)  Luminance_offset  <= Luminance_offset - 1'b1;
                    end
                    default: begin
                        rotation_offset   <= rotation_offset + ROT_W'(ROT_BASE);
                        Saturation_offset <= '1;
                        Luminance_offset  <= '1;
                    end
                endcase
            end
            if (mode_nxt == M_IDLE) invert_colors <= 1'b0;
        end
    end

endmodule

// File: tb/tb_game_fx_sequencer.sv
// Bench for game_fx_sequencer: a frame-level reference model pushes expected
// outputs to a scoreboard queue; each scenario task pops and compares after the tick.
module tb_game_fx_sequencer;

    typedef logic [30:0] fx_t;

    logic       Clk = 1'b0;
    logic       Reset_h = 1'b1;
    logic       VGA_VS = 1'b1;
    logic [2:0] State = 3'd0;
    logic [9:0] rotation_offset;
    logic [5:0] Hue_offset;
    logic [4:0] Saturation_offset, Luminance_offset;
    logic       move_walls, invert_colors;
    logic [2:0] level;

    int total = 0;
    int bad = 0;
    fx_t sb[$];
    fx_t got, expv;

    // reference model state
    int m_rot, m_hue, m_hcnt, m_sat, m_lum, m_lup, m_lvl, m_dir;
    int m_rev, m_wall, m_lcnt, m_inv, m_icnt, m_mode, m_mw;

    game_fx_sequencer #(
        .REV_FRAMES(5), .FRAMES_PER_LEVEL(8), .INVERT_LEVEL(1), .INVERT_PERIOD(3)
    ) dut (
        .Clk(Clk), .Reset_h(Reset_h), .VGA_VS(VGA_VS), .State(State),
        .rotation_offset(rotation_offset), .Hue_offset(Hue_offset),
        .Saturation_offset(Saturation_offset), .Luminance_offset(Luminance_offset),
        .move_walls(move_walls), .invert_colors(invert_colors), .level(level)
    );

    always #5 Clk = ~Clk;

    function automatic fx_t snap();
        return {rotation_offset, Hue_offset, Saturation_offset, Luminance_offset,
                move_walls, invert_colors, level};
    endfunction

    function automatic fx_t m_pack(int mw);
        return {10'(m_rot), 6'(m_hue), 5'(m_sat), 5'(m_lum), 1'(mw), 1'(m_inv), 3'(m_lvl)};
    endfunction

    task automatic m_reset();
        m_rot = 0; m_hue = 0; m_hcnt = 0; m_sat = 31; m_lum = 31; m_lup = 0;
        m_lvl = 0; m_dir = 0; m_rev = 0; m_wall = 0; m_lcnt = 0; m_inv = 0;
        m_icnt = 0; m_mode = 0; m_mw = 0;
    endtask

    task automatic m_state(int s);
        int nm;
        nm = (s == 1) ? 1 : (s == 2) ? 2 : 0;
        if (nm == 1 && m_mode != 1) begin
            m_lvl = 0; m_rev = 0; m_wall = 0; m_lcnt = 0; m_icnt = 0; m_hcnt = 0;
            m_inv = 0; m_dir = 0; m_lup = 0; m_sat = 31; m_lum = 31;
        end
        if (nm == 0) m_inv = 0;
        m_mode = nm;
    endtask

    task automatic m_tick();
        int stp;
        m_mw = 0;
        if (m_mode != 2) begin
            m_hcnt++;
            if (m_hcnt == 2) begin m_hcnt = 0; m_hue = (m_hue + 1) % 64; end
        end
        if (m_mode == 0) begin
            m_rot = (m_rot + 2) % 1024; m_sat = 31; m_lum = 31;
        end else if (m_mode == 1) begin
            stp = 2 + m_lvl;
            m_rot = (m_dir == 0) ? (m_rot + stp) % 1024 : (m_rot + 1024 - stp) % 1024;
            m_rev++;
            if (m_rev == 5) begin m_rev = 0; m_dir = 1 - m_dir; end
            if (m_lup == 0) begin
                if (m_lum == 16) begin m_lup = 1; m_lum = 17; end else m_lum--;
            end else begin
                if (m_lum == 31) begin m_lup = 0; m_lum = 30; end else m_lum++;
            end
            m_wall++;
            if (m_wall % 4 == 0) m_mw = 1;
            if (m_lvl >= 1) begin
                m_icnt++;
                if (m_icnt == 3) begin m_icnt = 0; m_inv = 1 - m_inv; end
            end
            m_lcnt++;
            if (m_lcnt == 8) begin m_lcnt = 0; if (m_lvl < 7) m_lvl++; end
        end else begin
            if (m_sat > 0) m_sat--;
            if (m_lum > 0) m_lum--;
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_h = 1'b1; VGA_VS = 1'b1; State = 3'd0;
        m_reset();
        repeat (2) @(negedge Clk);
        Reset_h = 1'b0;
    endtask

    // one VGA frame; the tick edge is the posedge following VGA_VS rising
    task automatic frame();
        @(negedge Clk) VGA_VS = 1'b0;
        repeat (2) @(negedge Clk);
        VGA_VS = 1'b1;
        m_tick();
        sb.push_back(m_pack(m_mw));
        @(posedge Clk); #1;
    endtask

    task automatic set_state(int s);
        @(negedge Clk) State = 3'(s);
        m_state(s);
        sb.push_back(m_pack(0));
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge Clk); #1;
        expv = {10'd0, 6'd0, 5'd31, 5'd31, 1'b0, 1'b0, 3'd0};
        for (int i = 0; i < 10; i++) begin
            got = snap();
            total++;
            if (got !== expv) begin
                bad++;
                $display("FAIL reset_hold cyc%0d got=%h exp=%h", i, got, expv);
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_idle();
        for (int f = 1; f <= 5; f++) begin
            frame();
            expv = sb.pop_front(); got = snap(); total++;
            if (got !== expv) begin
                bad++; $display("FAIL idle_frame f%0d got=%h exp=%h", f, got, expv);
            end
        end
        total++;
        if (rotation_offset !== 10'd10 || Hue_offset !== 6'd2) begin
            bad++; $display("FAIL idle_final rot=%0d hue=%0d exp rot=10 hue=2", rotation_offset, Hue_offset);
        end
    endtask

    task automatic test_walls();
        set_state(1);
        expv = sb.pop_front(); got = snap(); total++;
        if (got !== expv) begin
            bad++; $display("FAIL enter_play got=%h exp=%h", got, expv);
        end
        for (int f = 1; f <= 12; f++) begin
            frame();
            expv = sb.pop_front(); got = snap(); total++;
            if (got !== expv) begin
                bad++; $display("FAIL walls_frame f%0d got=%h exp=%h", f, got, expv);
            end
            @(posedge Clk); #1;
            total++;
            if (move_walls !== 1'b0) begin
                bad++; $display("FAIL walls_one_clk f%0d got=%b exp=0", f, move_walls);
            end
        end
        total++;
        if (Luminance_offset !== 5'd19) begin
            bad++; $display("FAIL walls_lum got=%0d exp=19", Luminance_offset);
        end
    endtask

    task automatic test_level_rotation();
        do_reset();
        set_state(1);
        void'(sb.pop_front());
        for (int f = 1; f <= 10; f++) begin
            frame();
            expv = sb.pop_front(); got = snap(); total++;
            if (got !== expv) begin
                bad++; $display("FAIL rot_frame f%0d got=%h exp=%h", f, got, expv);
            end
            if (f == 8) begin
                total++;
                if (rotation_offset !== 10'd4 || level !== 3'd1) begin
                    bad++; $display("FAIL rot_t8 rot=%0d lvl=%0d exp rot=4 lvl=1", rotation_offset, level);
                end
            end
            if (f == 10) begin
                total++;
                if (rotation_offset !== 10'd1022) begin
                    bad++; $display("FAIL rot_wrap got=%0d exp=1022", rotation_offset);
                end
            end
        end
    endtask

    task automatic test_invert();
        do_reset();
        set_state(1);
        void'(sb.pop_front());
        for (int f = 1; f <= 17; f++) begin
            frame();
            expv = sb.pop_front(); got = snap(); total++;
            if (got !== expv) begin
                bad++; $display("FAIL inv_frame f%0d got=%h exp=%h", f, got, expv);
            end
            if (f == 10 || f == 11 || f == 14) begin
                total++;
                if (invert_colors !== (f == 11)) begin
                    bad++; $display("FAIL inv_edge f%0d got=%b exp=%b", f, invert_colors, f == 11);
                end
            end
        end
        set_state(0);
        expv = sb.pop_front(); got = snap(); total++;
        if (got !== expv || invert_colors !== 1'b0) begin
            bad++; $display("FAIL inv_clear got=%h exp=%h", got, expv);
        end
    endtask

    task automatic test_over();
        do_reset();
        set_state(1);
        void'(sb.pop_front());
        for (int f = 1; f <= 11; f++) begin
            frame();
            void'(sb.pop_front());
        end
        total++;
        if (Luminance_offset !== 5'd20 || level !== 3'd1) begin
            bad++; $display("FAIL over_pre lum=%0d lvl=%0d exp lum=20 lvl=1", Luminance_offset, level);
        end
        set_state(2);
        void'(sb.pop_front());
        for (int f = 1; f <= 25; f++) begin
            frame();
            expv = sb.pop_front(); got = snap(); total++;
            if (got !== expv) begin
                bad++; $display("FAIL over_frame f%0d got=%h exp=%h", f, got, expv);
            end
        end
        total++;
        if (Saturation_offset !== 5'd6 || Luminance_offset !== 5'd0) begin
            bad++; $display("FAIL over_fade sat=%0d lum=%0d exp sat=6 lum=0", Saturation_offset, Luminance_offset);
        end
        // re-enter PLAY on the same edge as a frame tick: the clear must win
        @(negedge Clk) VGA_VS = 1'b0;
        repeat (2) @(negedge Clk);
        VGA_VS = 1'b1; State = 3'd1;
        m_state(1);
        sb.push_back(m_pack(0));
        @(posedge Clk); #1;
        expv = sb.pop_front(); got = snap(); total++;
        if (got !== expv) begin
            bad++; $display("FAIL replay_coincident got=%h exp=%h", got, expv);
        end
        total++;
        if (Saturation_offset !== 5'd31 || Luminance_offset !== 5'd31 || level !== 3'd0) begin
            bad++; $display("FAIL replay_clear sat=%0d lum=%0d lvl=%0d exp 31 31 0",
                            Saturation_offset, Luminance_offset, level);
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_idle();
        test_walls();
        test_level_rotation();
        test_invert();
        test_over();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
